// File: rtl/sr_sw_ram_fifo_if.sv
// Valid/ready handshake bundle for the RAM-backed FIFO: producer push side and consumer pop side.
// The FIFO takes the slave modport; the bench or the neighbouring pipeline stage takes master.
interface sr_sw_ram_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sr_sw_ram_fifo.sv
// Elastic valid/ready FIFO built on one behavioural RAM (registered write, async read).
// Latency: a word pushed in cycle N is at out_data with out_valid in cycle N+1.
// Backpressure: in_ready = !full, out_valid = !empty, both from registered count only.
module sr_sw_beh_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     chip_select,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]    read_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (chip_select && write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = (chip_select && read_enable) ? mem[read_addr] : '0;
endmodule

module sr_sw_ram_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH   = $clog2(DEPTH + 1),
    parameter int AFULL_LEVEL   = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sr_sw_ram_fifo_if.slave        bus,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   overflow
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0]   FULL_CNT  = COUNT_WIDTH'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push        = bus.in_valid && !full;
    assign pop         = bus.out_ready && !empty;
    assign almost_full = (count >= COUNT_WIDTH'(AFULL_LEVEL));

    sr_sw_beh_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk          (clk),
        .chip_select  (1'b1),
        .read_enable  (1'b1),
        .write_enable (push),
        .write_addr   (wr_ptr),
        .write_data   (bus.in_data),
        .read_addr    (rd_ptr),
        .read_data    (bus.out_data)
    );

    // Explicit wrap so non-power-of-two depths index only valid RAM rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDRESS_WIDTH'(1);
            end
            if (push && !pop) begin
                count <= count + COUNT_WIDTH'(1);
            end else if (pop && !push) begin
                count <= count - COUNT_WIDTH'(1);
            end
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Pointer difference aliases to zero when full, so the occupancy check skips that case.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(count) <= DEPTH);
            assert (int'(wr_ptr) < DEPTH);
            assert (int'(rd_ptr) < DEPTH);
            assert (full || (int'(count) == (int'(wr_ptr) + DEPTH - int'(rd_ptr)) % DEPTH));
        end
    end
endmodule

// File: tb/tb_sr_sw_ram_fifo.sv
// Directed bench: DEPTH=4 instance for reset/fill/overflow/stream/mid-reset, DEPTH=3 for wrap order.
module tb_sr_sw_ram_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count4;
    logic       afull4;
    logic       ovf4;
    logic [1:0] count3;
    logic       afull3;
    logic       ovf3;

    int vectors    = 0;
    int miscompares = 0;

    sr_sw_ram_fifo_if #(.DATA_WIDTH(8)) f4 ();
    sr_sw_ram_fifo_if #(.DATA_WIDTH(8)) f3 ();

    sr_sw_ram_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (f4.slave),
        .count       (count4),
        .almost_full (afull4),
        .overflow    (ovf4)
    );

    sr_sw_ram_fifo #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .bus         (f3.slave),
        .count       (count3),
        .almost_full (afull3),
        .overflow    (ovf3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    logic [7:0] fill_dat [4];
    logic [7:0] q3 [$];
    logic [7:0] next3;
    logic [10:0] push_pat;
    logic [10:0] pop_pat;

    initial begin
        fill_dat[0] = 8'h11; fill_dat[1] = 8'h22; fill_dat[2] = 8'h33; fill_dat[3] = 8'h44;
        rst = 1'b1;
        f4.in_valid = 1'b0; f4.in_data = 8'h00; f4.out_ready = 1'b0;
        f3.in_valid = 1'b0; f3.in_data = 8'h00; f3.out_ready = 1'b0;

        // Reset, two cycles
        repeat (2) @(negedge clk);
        chk("rst_in_ready", f4.in_ready, 1);
        chk("rst_out_valid", f4.out_valid, 0);
        chk("rst_count", count4, 0);
        chk("rst_afull", afull4, 0);
        chk("rst_overflow", ovf4, 0);
        chk("rst_count3", count3, 0);
        rst = 1'b0;

        // Fill with consumer stalled
        for (int i = 0; i < 4; i++) begin
            f4.in_valid = 1'b1;
            f4.in_data  = fill_dat[i];
            @(negedge clk);
            chk("fill_count", count4, i + 1);
            chk("fill_afull", afull4, (i + 1 >= 3) ? 1 : 0);
            chk("fill_in_ready", f4.in_ready, (i + 1 < 4) ? 1 : 0);
            chk("fill_head", f4.out_data, 8'h11);
            chk("fill_out_valid", f4.out_valid, 1);
        end
        f4.in_valid = 1'b0;
        @(negedge clk);
        chk("full_ovf_clear", ovf4, 0);

        // Push into a full FIFO
        f4.in_valid = 1'b1;
        f4.in_data  = 8'h55;
        @(negedge clk);
        f4.in_valid = 1'b0;
        chk("ovf_set", ovf4, 1);
        chk("ovf_count", count4, 4);
        chk("ovf_head", f4.out_data, 8'h11);
        @(negedge clk);
        chk("ovf_sticky", ovf4, 1);

        // Drain
        f4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", f4.out_valid, 1);
            chk("drain_data", f4.out_data, fill_dat[i]);
            chk("drain_count", count4, 4 - i);
            chk("drain_in_ready", f4.in_ready, (i == 0) ? 0 : 1);
            @(negedge clk);
        end
        chk("drain_empty", f4.out_valid, 0);
        chk("drain_count0", count4, 0);
        chk("drain_ovf_sticky", ovf4, 1);
        chk("drain_afull", afull4, 0);

        // Streaming push+pop, 20 words
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                chk("stream_count", count4, 1);
                chk("stream_data", f4.out_data, i - 1);
                chk("stream_in_ready", f4.in_ready, 1);
            end
            f4.in_valid = 1'b1;
            f4.in_data  = 8'(i);
            f4.out_ready = 1'b1;
            @(negedge clk);
        end
        f4.in_valid = 1'b0;
        chk("stream_tail_count", count4, 1);
        chk("stream_tail_data", f4.out_data, 19);
        @(negedge clk);
        chk("stream_done_count", count4, 0);
        chk("stream_done_valid", f4.out_valid, 0);
        f4.out_ready = 1'b0;

        // Reset mid-operation
        f4.in_valid = 1'b1; f4.in_data = 8'hA1;
        @(negedge clk);
        f4.in_data = 8'hA2;
        @(negedge clk);
        chk("mid_pre_count", count4, 2);
        rst = 1'b1;
        f4.in_data = 8'hA3;
        @(negedge clk);
        rst = 1'b0;
        f4.in_valid = 1'b0;
        chk("mid_count", count4, 0);
        chk("mid_out_valid", f4.out_valid, 0);
        chk("mid_overflow", ovf4, 0);
        chk("mid_in_ready", f4.in_ready, 1);
        @(negedge clk);
        chk("mid_after_count", count4, 0);
        chk("mid_after_valid", f4.out_valid, 0);
        f4.in_valid = 1'b1; f4.in_data = 8'hB0;
        @(negedge clk);
        f4.in_valid = 1'b0;
        chk("mid_fresh_data", f4.out_data, 8'hB0);
        chk("mid_fresh_count", count4, 1);

        // DEPTH=3 interleaved push/pop; pattern bit c applies in cycle c
        push_pat = 11'b01010101111;
        pop_pat  = 11'b11101110100;
        next3 = 8'h30;
        for (int c = 0; c < 11; c++) begin
            chk("d3_count", count3, q3.size());
            chk("d3_out_valid", f3.out_valid, (q3.size() > 0) ? 1 : 0);
            chk("d3_in_ready", f3.in_ready, (q3.size() < 3) ? 1 : 0);
            chk("d3_afull", afull3, (q3.size() >= 2) ? 1 : 0);
            if (q3.size() > 0) chk("d3_data", f3.out_data, q3[0]);
            f3.in_valid  = push_pat[c];
            f3.in_data   = next3;
            f3.out_ready = pop_pat[c];
            if (f3.out_ready && q3.size() > 0) void'(q3.pop_front());
            if (f3.in_valid && q3.size() < 3 + (pop_pat[c] ? 1 : 0)) begin
                q3.push_back(next3);
                next3++;
            end
            @(negedge clk);
        end
        f3.in_valid = 1'b0;
        f3.out_ready = 1'b0;
        chk("d3_end_count", count3, 0);
        chk("d3_end_valid", f3.out_valid, 0);
        chk("d3_pushed", next3, 8'h37);
        chk("d3_ovf", ovf3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
